// File: rtl/seq_rec_pkg.sv
// Shared types and constants for the serial sequence recognizer sequencer.
package seq_rec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int Z_MEALY    = 0;
    localparam int Z_MOORE    = 1;
    localparam int WORD_W_DEF = 8;

endpackage

// File: rtl/seq_recognizer_sequencer_word_serializer.sv
// Holds the latched word and bit order, presents one bit per advance and
// flags the last bit of the word.
module word_serializer
    import seq_rec_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    localparam int IDX_W = $clog2(WORD_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [WORD_W-1:0] word,
    input  logic              msb_first,
    output logic              bit_out,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    logic [WORD_W-1:0] word_q;
    logic              msb_q;
    logic [IDX_W-1:0]  bit_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= '0;
            msb_q  <= 1'b0;
            idx    <= '0;
        end else if (load) begin
            word_q <= word;
            msb_q  <= msb_first;
            idx    <= '0;
        end else if (advance && !last) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign last    = (idx == IDX_W'(WORD_W - 1));
    assign bit_sel = msb_q ? (IDX_W'(WORD_W - 1) - idx) : idx;
    assign bit_out = word_q[bit_sel];

endmodule

// File: rtl/seq_recognizer_sequencer.sv
// Word-level sequencer for a single-bit serial recognizer: optional history
// clear, bit-serial shift, per-bit hit capture and a done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; recognizer sees x=0
//   CLR   | recognizer reset held low for one cycle
//   SHIFT | one word bit per cycle on rec_x, z_in credited to a bit index
//   DRAIN | Moore only: collect z for the last bit
//   DONE  | done pulse, results valid
module seq_recognizer_sequencer
    import seq_rec_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int Z_LAT  = Z_MEALY,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    input  logic              msb_first,
    input  logic              clear_hist,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hit_mask,
    output logic [CNT_W-1:0]  hit_count,
    output logic              rec_x,
    output logic              rec_reset_n,
    input  logic              z_in
);

    localparam int IDX_W = $clog2(WORD_W);

    state_t           state;
    logic             load;
    logic             cur_bit;
    logic             last;
    logic [IDX_W-1:0] idx;

    assign load = (state == IDLE) && start;

    word_serializer #(.WORD_W(WORD_W)) u_ser (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .advance   (state == SHIFT),
        .word      (word),
        .msb_first (msb_first),
        .bit_out   (cur_bit),
        .idx       (idx),
        .last      (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            hit_mask  <= '0;
            hit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hit_mask  <= '0;
                        hit_count <= '0;
                        state     <= clear_hist ? CLR : SHIFT;
                    end
                end
                CLR: state <= SHIFT;
                SHIFT: begin
                    // Moore z lags x by one cycle, so it belongs to the previous bit
                    if (Z_LAT == Z_MEALY) begin
                        if (z_in) begin
                            hit_mask[idx] <= 1'b1;
                            hit_count     <= hit_count + CNT_W'(1);
                        end
                    end else if (z_in && (idx != '0)) begin
                        hit_mask[idx - IDX_W'(1)] <= 1'b1;
                        hit_count                 <= hit_count + CNT_W'(1);
                    end
                    if (last)
                        state <= (Z_LAT == Z_MOORE) ? DRAIN : DONE;
                end
                DRAIN: begin
                    if (z_in) begin
                        hit_mask[WORD_W-1] <= 1'b1;
                        hit_count          <= hit_count + CNT_W'(1);
                    end
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign rec_x       = (state == SHIFT) && cur_bit;
    // Combinational so the recognizer is held in reset during the controller's reset cycle
    assign rec_reset_n = !reset && (state != CLR);

endmodule

// File: tb/tb_seq_recognizer_sequencer.sv
// Bench: Mealy and Moore "11" recognizer stubs around two sequencer instances,
// a word-level timeline model compared every cycle, plus literal scenario checks.
module tb_seq_recognizer_sequencer;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [W-1:0]  word = '0;
    logic          msb_first = 1'b0, clear_hist = 1'b0;

    logic          busy_a, done_a, rx_a, rrn_a, z_a;
    logic          busy_b, done_b, rx_b, rrn_b, z_b;
    logic [W-1:0]  mask_a, mask_b;
    logic [CW-1:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    seq_recognizer_sequencer #(.WORD_W(W), .Z_LAT(0)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .word(word),
        .msb_first(msb_first), .clear_hist(clear_hist), .busy(busy_a),
        .done(done_a), .hit_mask(mask_a), .hit_count(cnt_a), .rec_x(rx_a),
        .rec_reset_n(rrn_a), .z_in(z_a)
    );

    seq_recognizer_sequencer #(.WORD_W(W), .Z_LAT(1)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .word(word),
        .msb_first(msb_first), .clear_hist(clear_hist), .busy(busy_b),
        .done(done_b), .hit_mask(mask_b), .hit_count(cnt_b), .rec_x(rx_b),
        .rec_reset_n(rrn_b), .z_in(z_b)
    );

    // Recognizer stubs: overlapping "11"
    logic prev_a = 1'b0, prev_b = 1'b0, zr_b = 1'b0;
    always @(posedge clock) begin
        if (!rrn_a) prev_a <= 1'b0;
        else        prev_a <= rx_a;
    end
    assign z_a = rx_a & prev_a;

    always @(posedge clock) begin
        if (!rrn_b) begin
            prev_b <= 1'b0;
            zr_b   <= 1'b0;
        end else begin
            prev_b <= rx_b;
            zr_b   <= rx_b & prev_b;
        end
    end
    assign z_b = zr_b;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] pres(input logic [W-1:0] w, input bit msb);
        logic [W-1:0] s;
        for (int i = 0; i < W; i++) s[i] = msb ? w[W-1-i] : w[i];
        return s;
    endfunction

    // A bit hits when it and the bit presented before it are both 1; the
    // recognizer always sees x=0 just before the first bit.
    function automatic logic [W-1:0] pair_hits(input logic [W-1:0] s);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = s[i] & ((i > 0) ? s[i-1] : 1'b0);
        return m;
    endfunction

    function automatic int popc(input logic [W-1:0] m);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(m[i]);
        return n;
    endfunction

    // Timeline model: p = cycle index since acceptance (0 = idle)
    int           m_p[2];
    int           m_tot[2];
    bit           m_clr[2];
    logic [W-1:0] m_seq[2];
    logic [W-1:0] m_res[2];
    int           m_cnt[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_p[k] = 0; m_tot[k] = 1; m_clr[k] = 0;
            m_seq[k] = '0; m_res[k] = '0; m_cnt[k] = 0;
        end
    end

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_p[k] = 0; m_res[k] = '0; m_cnt[k] = 0;
            end else if (m_p[k] == 0) begin
                if ((k == 1) ? start_b : start_a) begin
                    m_p[k]   = 1;
                    m_clr[k] = clear_hist;
                    m_seq[k] = pres(word, msb_first);
                    m_tot[k] = 1 + int'(clear_hist) + W + k;
                    m_res[k] = pair_hits(m_seq[k]);
                    m_cnt[k] = popc(m_res[k]);
                end
            end else if (m_p[k] == m_tot[k]) begin
                m_p[k] = 0;
            end else begin
                m_p[k] = m_p[k] + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic ob, od, ox, orr, ex;
                logic [W-1:0] om;
                logic [CW-1:0] oc;
                int first;
                bit edone;
                ob  = k ? busy_b : busy_a;
                od  = k ? done_b : done_a;
                ox  = k ? rx_b   : rx_a;
                orr = k ? rrn_b  : rrn_a;
                om  = k ? mask_b : mask_a;
                oc  = k ? cnt_b  : cnt_a;
                edone = (m_p[k] != 0) && (m_p[k] == m_tot[k]);
                first = 1 + int'(m_clr[k]);
                ex = 1'b0;
                if (m_p[k] >= first && m_p[k] < first + W) ex = m_seq[k][m_p[k] - first];
                check($sformatf("model busy[%0d]", k), ob, (m_p[k] != 0));
                check($sformatf("model done[%0d]", k), od, edone);
                check($sformatf("model rec_x[%0d]", k), ox, ex);
                check($sformatf("model rec_reset_n[%0d]", k), orr,
                      !reset && !(m_clr[k] && m_p[k] == 1));
                if (m_p[k] == 0 || edone) begin
                    check($sformatf("model hit_mask[%0d]", k), om, m_res[k]);
                    check($sformatf("model hit_count[%0d]", k), oc, m_cnt[k]);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_word(input int k, input logic [W-1:0] w, input bit msb, input bit clr,
                            input int exp_lat, input logic [W-1:0] exp_mask, input int exp_cnt,
                            input logic [15:0] exp_xs, input int exp_rlow);
        logic [15:0] xs = '0;
        int rlow = 0, lat = -1;
        logic [W-1:0] gm = '0;
        logic [CW-1:0] gc = '0;
        word = w; msb_first = msb; clear_hist = clr;
        if (k == 1) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clock);
            if (k == 1 ? done_b : done_a) begin
                lat = c;
                gm = k ? mask_b : mask_a;
                gc = k ? cnt_b : cnt_a;
            end else begin
                xs = {xs[14:0], (k ? rx_b : rx_a)};
                if (!(k ? rrn_b : rrn_a)) rlow++;
            end
        end
        check("latency", lat, exp_lat);
        check("hit_mask", gm, exp_mask);
        check("hit_count", gc, exp_cnt);
        check("rec_x sequence", xs, exp_xs);
        check("rec_reset_n low cycles", rlow, exp_rlow);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, pulses;
        @(posedge clock); #1;
        chk_en = 1'b1;
        @(negedge clock);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset hit_mask", mask_a, 0);
        check("reset rec_reset_n", rrn_a, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle rec_reset_n", rrn_a, 1);
        check("idle rec_x", rx_a, 0);
        @(posedge clock); #1;

        run_word(0, 8'b1110_0110, 1, 1, 10, 8'b0100_0110, 3, 16'h00E6, 1);
        run_word(0, 8'b1110_0110, 0, 0,  9, 8'b1100_0100, 3, 16'h0067, 0);
        run_word(1, 8'hFF,        1, 1, 11, 8'b1111_1110, 7, 16'h01FE, 1);

        // start pulsed mid-word, then held through DONE
        word = 8'b1110_0110; msb_first = 1'b1; clear_hist = 1'b0; start_a = 1'b1;
        @(posedge clock); #1; start_a = 1'b0;
        repeat (3) @(posedge clock);
        #1; word = 8'hFF; msb_first = 1'b0; clear_hist = 1'b1; start_a = 1'b1;
        @(posedge clock); #1; start_a = 1'b0;
        repeat (3) @(posedge clock);
        #1; start_a = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("b2b first done", done_a, 1);
        check("b2b first hit_mask", mask_a, 8'b0100_0110);
        check("b2b first hit_count", cnt_a, 3);
        @(posedge clock); #1;
        @(negedge clock);
        check("b2b idle gap busy", busy_a, 0);
        @(posedge clock); #1; start_a = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clock);
            if (done_a) lat = c;
        end
        check("b2b second latency", lat, 10);
        check("b2b second hit_mask", mask_a, 8'b1111_1110);
        check("b2b second hit_count", cnt_a, 7);
        @(posedge clock); #1;

        // reset at SHIFT idx=4
        word = 8'b1011_0111; msb_first = 1'b1; clear_hist = 1'b1; start_a = 1'b1;
        @(posedge clock); #1; start_a = 1'b0;
        repeat (5) @(posedge clock);
        #1; reset = 1'b1;
        @(negedge clock);
        check("mid reset rec_reset_n", rrn_a, 0);
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        check("after reset busy", busy_a, 0);
        check("after reset done", done_a, 0);
        check("after reset hit_mask", mask_a, 0);
        check("after reset hit_count", cnt_a, 0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (done_a) pulses++;
        end
        check("no done after abort", pulses, 0);
        @(posedge clock); #1;
        run_word(0, 8'b1011_0111, 0, 0, 9, 8'h26, 3, 16'h00ED, 0);

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
